// File: rtl/irq_pkg.sv
// Shared sizing and FSM state encoding for the priority interrupt controller.
package irq_pkg;
    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;
endpackage

// File: rtl/priority_irq_ctrl_if.sv
// CPU-side request/acknowledge handshake of the interrupt controller.
interface priority_irq_ctrl_if;
    import irq_pkg::*;

    logic              irq_o;
    logic [IDX_W-1:0]  vec_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              ack_i;
    logic              eoi_i;

    modport master (output irq_o, vec_o, data_o, busy_o, input ack_i, eoi_i);
    modport slave  (input irq_o, vec_o, data_o, busy_o, output ack_i, eoi_i);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: highest set bit wins, bit 3 highest.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        unique case (req_i) inside
            4'b1???: begin idx_o = 2'd3; valid_o = 1'b1; end
            4'b01??: begin idx_o = 2'd2; valid_o = 1'b1; end
            4'b001?: begin idx_o = 2'd1; valid_o = 1'b1; end
            4'b0001: begin idx_o = 2'd0; valid_o = 1'b1; end
            4'b0000: begin idx_o = 2'd0; valid_o = 1'b0; end
        endcase
    end
endmodule

// File: rtl/priority_irq_ctrl.sv
// Edge-triggered pending register feeding a non-preemptive IDLE/REQ/SERVICE grant FSM.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrate over pending & mask each cycle
// REQ     | irq_o high, vec_o/data_o frozen, waiting for ack_i
// SERVICE | busy_o high, CPU handling vec_o, waiting for eoi_i
module priority_irq_ctrl
    import irq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_SRC-1:0]  irq_i,
    input  logic [NUM_SRC-1:0]  mask_i,
    input  logic [DATA_W-1:0]   data3_i,
    input  logic [DATA_W-1:0]   data2_i,
    input  logic [DATA_W-1:0]   data1_i,
    input  logic [DATA_W-1:0]   data0_i,
    output logic [NUM_SRC-1:0]  pending_o,
    priority_irq_ctrl_if.master cpu
);
    state_e            state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic               armed_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               irq_out_q, irq_out_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   vec_q, vec_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [DATA_W-1:0]  data_arr [NUM_SRC];

    // armed_q suppresses the first post-reset sample so lines held high
    // through reset release are not mistaken for a fresh edge.
    assign rise = irq_i & ~irq_q & {NUM_SRC{armed_q}};

    irq_prio_enc u_prio_enc (
        .req_i   (pending_q & mask_i),
        .idx_o   (grant_idx),
        .valid_o (grant_vld)
    );

    always_comb begin
        data_arr[3] = data3_i;
        data_arr[2] = data2_i;
        data_arr[1] = data1_i;
        data_arr[0] = data0_i;
    end

    always_comb begin
        state_d   = state_q;
        irq_out_d = irq_out_q;
        busy_d    = busy_q;
        vec_d     = vec_q;
        data_d    = data_q;
        clr       = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d   = REQ;
                    irq_out_d = 1'b1;
                    vec_d     = grant_idx;
                    data_d    = data_arr[grant_idx];
                end
            end
            REQ: begin
                if (cpu.ack_i) begin
                    state_d    = SERVICE;
                    irq_out_d  = 1'b0;
                    busy_d     = 1'b1;
                    clr[vec_q] = 1'b1;
                end
            end
            SERVICE: begin
                if (cpu.eoi_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_out_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
        // A new edge wins over the acknowledge clear of the same bit.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            irq_out_q <= 1'b0;
            busy_q    <= 1'b0;
            vec_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_i;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            irq_out_q <= irq_out_d;
            busy_q    <= busy_d;
            vec_q     <= vec_d;
            data_q    <= data_d;
        end
    end

    assign pending_o  = pending_q;
    assign cpu.irq_o  = irq_out_q;
    assign cpu.busy_o = busy_q;
    assign cpu.vec_o  = vec_q;
    assign cpu.data_o = data_q;
endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Directed scenario bench for priority_irq_ctrl with hand-computed expectations.
module tb_priority_irq_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] irq_i;
    logic [3:0] mask_i;
    logic [7:0] data3_i, data2_i, data1_i, data0_i;
    logic [3:0] pending_o;
    int         errors = 0;
    int         checks = 0;

    priority_irq_ctrl_if cpu ();

    priority_irq_ctrl dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .irq_i     (irq_i),
        .mask_i    (mask_i),
        .data3_i   (data3_i),
        .data2_i   (data2_i),
        .data1_i   (data1_i),
        .data0_i   (data0_i),
        .pending_o (pending_o),
        .cpu       (cpu.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_ack();
        cpu.ack_i = 1'b1; tick(); cpu.ack_i = 1'b0;
    endtask

    task automatic do_eoi();
        cpu.eoi_i = 1'b1; tick(); cpu.eoi_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; irq_i = '0; mask_i = 4'hF;
        data3_i = 8'hC3; data2_i = 8'h22; data1_i = 8'h5A; data0_i = 8'h11;
        cpu.ack_i = 1'b0; cpu.eoi_i = 1'b0;
        #3;
        checks++; if (cpu.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", cpu.irq_o); end
        checks++; if (cpu.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cpu.busy_o); end
        checks++; if (cpu.vec_o !== 2'd0 || cpu.data_o !== 8'h00) begin errors++; $display("FAIL reset_vec_data: got %0d/%h want 0/00", cpu.vec_o, cpu.data_o); end
        checks++; if (pending_o !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending_o); end
        tick(); tick();
        rst_ni = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        mask_i = 4'hF;
        irq_i = 4'b0010; tick(); irq_i = '0;
        checks++; if (pending_o !== 4'b0010 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL single_latency: got pend=%b irq=%b want 0010/0", pending_o, cpu.irq_o); end
        tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd1 || cpu.data_o !== 8'h5A) begin errors++; $display("FAIL single_req: got irq=%b vec=%0d data=%h want 1/1/5a", cpu.irq_o, cpu.vec_o, cpu.data_o); end
        do_ack();
        checks++; if (cpu.busy_o !== 1'b1 || cpu.irq_o !== 1'b0 || pending_o !== 4'b0000) begin errors++; $display("FAIL single_ack: got busy=%b irq=%b pend=%b want 1/0/0000", cpu.busy_o, cpu.irq_o, pending_o); end
        do_eoi();
        checks++; if (cpu.busy_o !== 1'b0 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL single_eoi: got busy=%b irq=%b want 0/0", cpu.busy_o, cpu.irq_o); end
    endtask

    task automatic test_priority();
        irq_i = 4'b1010; tick(); irq_i = '0; tick();
        checks++; if (cpu.vec_o !== 2'd3 || cpu.data_o !== 8'hC3 || pending_o !== 4'b1010) begin errors++; $display("FAIL prio_first: got vec=%0d data=%h pend=%b want 3/c3/1010", cpu.vec_o, cpu.data_o, pending_o); end
        do_ack();
        checks++; if (pending_o !== 4'b0010) begin errors++; $display("FAIL prio_ack_clear: got %b want 0010", pending_o); end
        do_eoi();
        checks++; if (cpu.irq_o !== 1'b0 || cpu.busy_o !== 1'b0) begin errors++; $display("FAIL prio_gap: got irq=%b busy=%b want 0/0", cpu.irq_o, cpu.busy_o); end
        tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd1 || cpu.data_o !== 8'h5A) begin errors++; $display("FAIL prio_second: got irq=%b vec=%0d data=%h want 1/1/5a", cpu.irq_o, cpu.vec_o, cpu.data_o); end
        do_ack();
        checks++; if (pending_o !== 4'b0000) begin errors++; $display("FAIL prio_second_ack: got %b want 0000", pending_o); end
        do_eoi();
    endtask

    task automatic test_mask();
        mask_i = 4'b0111;
        irq_i = 4'b1000; tick(); irq_i = '0; tick(); tick();
        checks++; if (pending_o !== 4'b1000 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL mask_hold: got pend=%b irq=%b want 1000/0", pending_o, cpu.irq_o); end
        mask_i = 4'hF; tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd3) begin errors++; $display("FAIL mask_release: got irq=%b vec=%0d want 1/3", cpu.irq_o, cpu.vec_o); end
        mask_i = 4'b0000; tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd3) begin errors++; $display("FAIL mask_in_req: got irq=%b vec=%0d want 1/3", cpu.irq_o, cpu.vec_o); end
        mask_i = 4'hF;
        do_ack(); do_eoi();
    endtask

    task automatic test_ignore();
        cpu.ack_i = 1'b1; tick(); cpu.ack_i = 1'b0;
        checks++; if (cpu.busy_o !== 1'b0 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL ack_in_idle: got busy=%b irq=%b want 0/0", cpu.busy_o, cpu.irq_o); end
        irq_i = 4'b0100; tick(); irq_i = '0; tick();
        do_eoi();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.busy_o !== 1'b0 || cpu.vec_o !== 2'd2) begin errors++; $display("FAIL eoi_in_req: got irq=%b busy=%b vec=%0d want 1/0/2", cpu.irq_o, cpu.busy_o, cpu.vec_o); end
        do_ack(); do_ack();
        checks++; if (cpu.busy_o !== 1'b1 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL ack_in_service: got busy=%b irq=%b want 1/0", cpu.busy_o, cpu.irq_o); end
        do_eoi();
    endtask

    task automatic test_no_preempt();
        irq_i = 4'b0001; tick(); irq_i = '0; tick();
        do_ack();
        irq_i = 4'b0100; tick(); irq_i = '0; tick();
        checks++; if (cpu.busy_o !== 1'b1 || cpu.vec_o !== 2'd0 || pending_o !== 4'b0100 || cpu.data_o !== 8'h11) begin errors++; $display("FAIL no_preempt: got busy=%b vec=%0d pend=%b data=%h want 1/0/0100/11", cpu.busy_o, cpu.vec_o, pending_o, cpu.data_o); end
        do_eoi();
        checks++; if (cpu.busy_o !== 1'b0 || cpu.irq_o !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b irq=%b want 0/0", cpu.busy_o, cpu.irq_o); end
        tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd2 || cpu.data_o !== 8'h22) begin errors++; $display("FAIL b2b_rearb: got irq=%b vec=%0d data=%h want 1/2/22", cpu.irq_o, cpu.vec_o, cpu.data_o); end
        do_ack(); do_eoi();
    endtask

    task automatic test_set_over_clear();
        irq_i = 4'b0010; tick(); irq_i = '0; tick();
        irq_i = 4'b0010; cpu.ack_i = 1'b1; tick(); irq_i = '0; cpu.ack_i = 1'b0;
        checks++; if (pending_o !== 4'b0010 || cpu.busy_o !== 1'b1) begin errors++; $display("FAIL set_over_clear: got pend=%b busy=%b want 0010/1", pending_o, cpu.busy_o); end
        do_eoi(); tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd1) begin errors++; $display("FAIL set_over_clear_regrant: got irq=%b vec=%0d want 1/1", cpu.irq_o, cpu.vec_o); end
        do_ack(); do_eoi();
    endtask

    task automatic test_reset_mid_req();
        irq_i = 4'b0001; tick(); tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.data_o !== 8'h11) begin errors++; $display("FAIL rst_setup: got irq=%b data=%h want 1/11", cpu.irq_o, cpu.data_o); end
        #2 rst_ni = 1'b0; #1;
        checks++; if (cpu.irq_o !== 1'b0 || cpu.busy_o !== 1'b0 || cpu.vec_o !== 2'd0 || cpu.data_o !== 8'h00 || pending_o !== 4'b0000) begin errors++; $display("FAIL rst_async: got irq=%b busy=%b vec=%0d data=%h pend=%b want all 0", cpu.irq_o, cpu.busy_o, cpu.vec_o, cpu.data_o, pending_o); end
        tick();
        rst_ni = 1'b1;
        tick(); tick(); tick();
        checks++; if (cpu.irq_o !== 1'b0 || pending_o !== 4'b0000) begin errors++; $display("FAIL rst_held_line: got irq=%b pend=%b want 0/0000", cpu.irq_o, pending_o); end
        irq_i = 4'b0000; tick();
        irq_i = 4'b0001; tick();
        checks++; if (pending_o !== 4'b0001) begin errors++; $display("FAIL rst_new_edge: got %b want 0001", pending_o); end
        tick();
        checks++; if (cpu.irq_o !== 1'b1 || cpu.vec_o !== 2'd0 || cpu.data_o !== 8'h11) begin errors++; $display("FAIL rst_regrant: got irq=%b vec=%0d data=%h want 1/0/11", cpu.irq_o, cpu.vec_o, cpu.data_o); end
        checks++; if (pending_o !== 4'b0001) begin errors++; $display("FAIL level_no_reset: got %b want 0001", pending_o); end
        irq_i = '0;
        do_ack(); do_eoi();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_ignore();
        test_no_preempt();
        test_set_over_clear();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
